multi_digit_decade_counter: RTL

Parametrised synchronous decade counter chaining `DIGITS` decimal digits, with a selectable output code, parallel load, count enable and terminal-count output. It generalises the single-digit 2421 counter used in lab 12. It drives multi-digit display, timer and frequency-count datapaths directly in 8421 BCD, 2421 or excess-3.

---
 rtl/decade_pkg.sv | 12 +
 rtl/decade_digit.sv | 21 ++
 rtl/multi_digit_decade_counter.sv | 37 +++
 3 files changed

// File: rtl/decade_pkg.sv
// decade_pkg: output code selectors, digit limits and the per-digit encoder
package decade_pkg;
  localparam int CODE_8421 = 0;
  localparam int CODE_2421 = 1;
  localparam int CODE_XS3 = 2;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] DIGIT_MIN = 4'd0;
  function automatic logic [3:0] encode_digit(input logic [3:0] value, input int code);
    return code == CODE_2421 ? (value > 4'd4 ? value + 4'd6 : value) :
           code == CODE_XS3  ? value + 4'd3 : value;
  endfunction
endpackage

// File: rtl/decade_digit.sv
// decade_digit: one binary 0-9 digit cell with load, up/down step and carry/borrow out
module decade_digit
  import decade_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       cin,
  input  logic       up,
  output logic [3:0] value,
  output logic       cout
);
  logic at_lim;
  assign at_lim = up ? value == DIGIT_MAX : value == DIGIT_MIN;
  assign cout = cin & at_lim;
  always_ff @(posedge CLK)
    if (RESET) value <= DIGIT_MIN;
    else if (load) value <= load_val > DIGIT_MAX ? DIGIT_MIN : load_val;
    else if (cin) value <= at_lim ? (up ? DIGIT_MIN : DIGIT_MAX) : (up ? value + 4'd1 : value - 4'd1);
endmodule

// File: rtl/multi_digit_decade_counter.sv
// multi_digit_decade_counter: DIGITS-digit decade counter with coded output.
// Define DECADE_UPDOWN_EN to add the UP port and down counting.
module multi_digit_decade_counter
  import decade_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int CODE = 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                EN,
  input  logic                LOAD,
  input  logic [4*DIGITS-1:0] LOAD_VAL,
`ifdef DECADE_UPDOWN_EN
  input  logic                UP,
`endif
  output logic [4*DIGITS-1:0] out,
  output logic                tc
);
  logic up;
  logic [DIGITS:0] carry;
`ifdef DECADE_UPDOWN_EN
  assign up = UP;
`else
  assign up = 1'b1;
`endif
  assign carry[0] = EN;
  assign tc = carry[DIGITS] & ~LOAD & ~RESET;
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    logic [3:0] value;
    decade_digit u_digit (
      .CLK(CLK), .RESET(RESET), .load(LOAD), .load_val(LOAD_VAL[4*d+:4]),
      .cin(carry[d]), .up(up), .value(value), .cout(carry[d+1])
    );
    assign out[4*d+:4] = encode_digit(value, CODE);
  end
endmodule
